// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite definitions: transfer type and size encodings, response
// codes, and the byte-strobe helper used by the SRAM responder.
package ahblite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_4W    = 3'd4,
        SIZE_8W    = 3'd5,
        SIZE_16W   = 3'd6,
        SIZE_32W   = 3'd7
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Only sizes up to a doubleword reach this helper, so size[1:0] is enough.
    function automatic logic [7:0] size_to_strb(input hsize_e size, input logic [2:0] offset);
        logic [8:0] mask;
        mask = (9'd1 << (4'd1 << size[1:0])) - 9'd1;
        return mask[7:0] << offset;
    endfunction

endpackage

// File: rtl/ahblite_excl_monitor.sv
// Single-entry exclusive-access monitor {valid, master, word}; only built
// when AHBL_SLV_EXCL_EN is defined.
module ahblite_excl_monitor
    import ahblite_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_set,
    input  logic              wr_commit,
    input  logic [3:0]        master,
    input  logic [WORD_W-1:0] word,
    output logic              match
);

    logic              valid_r;
    logic [3:0]        master_r;
    logic [WORD_W-1:0] word_r;

    // Arm on an exclusive read; any committed write to the watched word disarms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r  <= 1'b0;
            master_r <= 4'd0;
            word_r   <= {WORD_W{1'b0}};
        end else if (rd_set) begin
            valid_r  <= 1'b1;
            master_r <= master;
            word_r   <= word;
        end else if (wr_commit && (word_r == word)) begin
            valid_r  <= 1'b0;
        end
    end

    assign match = valid_r && (master_r == master) && (word_r == word);

endmodule

// File: rtl/ahblite_sram_slave.sv
// AHB-Lite SRAM responder with flop memory, programmable wait states and a
// two-cycle ERROR response. Define AHBL_SLV_EXCL_EN for exclusive-access support.
module ahblite_sram_slave
    import ahblite_pkg::*;
#(
    parameter int                     HADDR_WIDTH = 32,
    parameter int                     HDATA_WIDTH = 32,
    parameter int                     MEM_DEPTH   = 256,
    parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = {HADDR_WIDTH{1'b0}},
    parameter int                     WAIT_STATES = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic [2:0]             HSIZE,
    input  logic                   HWRITE,
    input  logic [HADDR_WIDTH-1:0] HADDR,
    input  logic [HDATA_WIDTH-1:0] HWDATA,
    input  logic                   HMASTLOCK,
    input  logic [6:0]             HPROT,
    input  logic                   HNONSEC,
    input  logic                   HEXCL,
    input  logic [3:0]             HMASTER,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [HDATA_WIDTH-1:0] HRDATA,
    output logic                   HEXOKAY
);

    localparam int         BL      = (HDATA_WIDTH == 64) ? 3 : 2;
    localparam int         NBYTES  = HDATA_WIDTH / 8;
    localparam int         WORD_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    state_e                   state_r;
    logic [3:0]               cnt_r;
    logic [WORD_W-1:0]        word_r;
    logic [2:0]               off_r;
    hsize_e                   size_r;
    logic                     write_r;
    logic                     excl_r;
    logic [3:0]               master_r;
    logic                     hreadyout_r;
    logic                     hresp_r;
    logic [HDATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

    htrans_e                  htrans_s;
    logic                     accept_s;
    logic [HADDR_WIDTH-1:0]   off_s;
    logic [HADDR_WIDTH-1:0]   word_full_s;
    logic [7:0]               size_mask_s;
    logic                     illegal_s;
    logic [2:0]               lane_off_s;
    logic [7:0]               strb_full_s;
    logic                     commit_s;
    logic                     excl_pass_s;
    logic [HDATA_WIDTH-1:0]   hrdata_s;
    logic                     unused_s;

    assign htrans_s    = htrans_e'(HTRANS);
    assign accept_s    = HSEL && HREADY && ((htrans_s == NONSEQ) || (htrans_s == SEQ));
    assign off_s       = HADDR - BASE_ADDR;
    assign word_full_s = off_s >> BL;
    assign size_mask_s = (8'd1 << HSIZE) - 8'd1;
    assign illegal_s   = (word_full_s >= HADDR_WIDTH'(MEM_DEPTH))
                      || (HSIZE > 3'(BL))
                      || ((size_mask_s & {5'd0, off_s[2:0]}) != 8'd0);

    assign lane_off_s  = off_r & 3'(NBYTES - 1);
    assign strb_full_s = size_to_strb(size_r, lane_off_s);
    assign commit_s    = (state_r == ST_LAST) && write_r && excl_pass_s;

    // Transfer sequencer; LAST and ERR2 accept the next address phase directly.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            word_r      <= {WORD_W{1'b0}};
            off_r       <= 3'd0;
            size_r      <= SIZE_BYTE;
            write_r     <= 1'b0;
            excl_r      <= 1'b0;
            master_r    <= 4'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r     <= ST_LAST;
                        hreadyout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_r     <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= HRESP_ERROR;
                end
                ST_IDLE, ST_LAST, ST_ERR2: begin
                    if (accept_s) begin
                        word_r   <= word_full_s[WORD_W-1:0];
                        off_r    <= off_s[2:0];
                        size_r   <= hsize_e'(HSIZE);
                        write_r  <= HWRITE;
                        excl_r   <= HEXCL;
                        master_r <= HMASTER;
                        if (illegal_s) begin
                            state_r     <= ST_ERR1;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= HRESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state_r     <= ST_LAST;
                            hreadyout_r <= 1'b1;
                            hresp_r     <= HRESP_OKAY;
                        end else begin
                            state_r     <= ST_WAIT;
                            cnt_r       <= WS_LOAD;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= HRESP_OKAY;
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Byte-strobed write at the edge closing LAST; the array itself is never reset.
    always_ff @(posedge HCLK) begin
        if (commit_s) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (strb_full_s[b]) begin
                    mem_r[word_r][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

    // Full word is driven during LAST only; lane selection is the master's job.
    always_comb begin
        hrdata_s = {HDATA_WIDTH{1'b0}};
        if (state_r == ST_LAST) begin
            hrdata_s = mem_r[word_r];
        end else begin
            hrdata_s = {HDATA_WIDTH{1'b0}};
        end
    end

`ifdef AHBL_SLV_EXCL_EN
    logic match_s;

    ahblite_excl_monitor #(
        .WORD_W(WORD_W)
    ) u_excl_monitor (
        .clk       (HCLK),
        .rst       (HRESET),
        .rd_set    ((state_r == ST_LAST) && excl_r && !write_r),
        .wr_commit (commit_s),
        .master    (master_r),
        .word      (word_r),
        .match     (match_s)
    );

    assign excl_pass_s = !(write_r && excl_r) || match_s;
    assign HEXOKAY     = (state_r == ST_LAST) && excl_r && (!write_r || match_s);
    assign unused_s    = ^{HBURST, HPROT, HMASTLOCK, HNONSEC, strb_full_s};
`else
    assign excl_pass_s = 1'b1;
    assign HEXOKAY     = 1'b0;
    assign unused_s    = ^{HBURST, HPROT, HMASTLOCK, HNONSEC, strb_full_s,
                           HEXCL, HMASTER, excl_r, master_r};
`endif

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = hrdata_s;

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Self-checking bench: three responders (0, 2 and 3 wait states) each on a
// private single-slave bus, checked against a word-array reference model.
module tb_ahblite_sram_slave;

    logic        clk;
    logic        hrst      [3];
    logic        hsel      [3];
    logic [1:0]  htrans    [3];
    logic [2:0]  hsize     [3];
    logic        hwrite    [3];
    logic [31:0] haddr     [3];
    logic [31:0] hwdata    [3];
    logic        hexcl     [3];
    logic [3:0]  hmaster   [3];
    logic        hreadyout [3];
    logic        hresp     [3];
    logic [31:0] hrdata    [3];
    logic        hexokay   [3];
    logic [2:0]  hburst;
    logic [6:0]  hprot;
    logic        hmastlock;
    logic        hnonsec;

    logic [31:0] ref_mem [3][256];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahblite_sram_slave #(
            .HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_DEPTH(256), .BASE_ADDR(32'h0),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .HCLK(clk), .HRESET(hrst[g]), .HSEL(hsel[g]), .HTRANS(htrans[g]),
            .HBURST(hburst), .HSIZE(hsize[g]), .HWRITE(hwrite[g]), .HADDR(haddr[g]),
            .HWDATA(hwdata[g]), .HMASTLOCK(hmastlock), .HPROT(hprot), .HNONSEC(hnonsec),
            .HEXCL(hexcl[g]), .HMASTER(hmaster[g]), .HREADY(hreadyout[g]),
            .HREADYOUT(hreadyout[g]), .HRESP(hresp[g]), .HRDATA(hrdata[g]), .HEXOKAY(hexokay[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic bit is_illegal(input logic [31:0] addr, input int size);
        return (addr / 32'd4 >= 32'd256) || (size > 2) || ((addr % (32'd1 << size)) != 32'd0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] addr, input int size);
        logic [31:0] r;
        int lo;
        int n;
        r  = old;
        lo = int'(addr % 32'd4);
        n  = 1 << size;
        for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + n) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    // One non-pipelined transfer: address phase, then the data phase until ready.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, input bit ex, input logic [3:0] mst,
                        output logic [31:0] rd, output logic rsp0, output logic rsp,
                        output logic eok, output int waits);
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = addr; hsize[d] = size;
        hwrite[d] = wr; hexcl[d] = ex; hmaster[d] = mst;
        @(posedge clk); #1;
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wd;
        rsp0 = hresp[d];
        waits = 0;
        while (hreadyout[d] !== 1'b1 && waits < 64) begin
            @(posedge clk); #1;
            waits++;
        end
        rd = hrdata[d]; rsp = hresp[d]; eok = hexokay[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0 || hexokay[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_values dut%0d: got rdy=%b resp=%b rdata=%h exok=%b exp 1 0 0 0",
                         d, hreadyout[d], hresp[d], hrdata[d], hexokay[d]);
            end
        end
    endtask

    task automatic init_mem();
        logic [31:0] rd, wd;
        logic r0, r1, eo;
        int w;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 18; i++) begin
                wd = $urandom;
                xfer(d, 1'b1, 32'(i * 4), 3'd2, wd, 1'b0, 4'd0, rd, r0, r1, eo, w);
                ref_mem[d][i] = wd;
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic r0, r1, eo;
        int w;
        xfer(0, 1'b1, 32'h10, 3'd2, 32'hA5A5_1234, 1'b0, 4'd1, rd, r0, r1, eo, w);
        ref_mem[0][4] = 32'hA5A5_1234;
        checks++;
        if (w !== 0 || r1 !== 1'b0) begin
            errors++; $display("FAIL basic_write: waits=%0d resp=%b exp 0 0", w, r1);
        end
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 4'd1, rd, r0, r1, eo, w);
        checks++;
        if (w !== 0 || r1 !== 1'b0 || rd !== 32'hA5A5_1234) begin
            errors++; $display("FAIL basic_read: waits=%0d resp=%b rdata=%h exp 0 0 a5a51234", w, r1, rd);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] rd;
        logic r0, r1, eo;
        int w;
        xfer(0, 1'b1, 32'h10, 3'd2, 32'h0, 1'b0, 4'd1, rd, r0, r1, eo, w);
        xfer(0, 1'b1, 32'h13, 3'd0, 32'hEE00_0000, 1'b0, 4'd1, rd, r0, r1, eo, w);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 4'd1, rd, r0, r1, eo, w);
        checks++;
        if (rd !== 32'hEE00_0000) begin
            errors++; $display("FAIL byte_lane: rdata=%h exp ee000000", rd);
        end
        xfer(0, 1'b1, 32'h12, 3'd1, 32'hBEEF_0000, 1'b0, 4'd1, rd, r0, r1, eo, w);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 4'd1, rd, r0, r1, eo, w);
        checks++;
        if (rd !== 32'hBEEF_0000) begin
            errors++; $display("FAIL half_lane: rdata=%h exp beef0000", rd);
        end
        ref_mem[0][4] = 32'hBEEF_0000;
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h0; hsize[1] = 3'd2;
        hwrite[1] = 1'b0; hexcl[1] = 1'b0; hmaster[1] = 4'd2;
        @(posedge clk); #1;
        haddr[1] = 32'h4;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i == 3) begin hsel[1] = 1'b0; htrans[1] = 2'b00; end
            exp_rdy = (i == 2 || i == 5);
            checks++;
            if (hreadyout[1] !== exp_rdy || hresp[1] !== 1'b0) begin
                errors++; $display("FAIL b2b_ready[%0d]: rdy=%b resp=%b exp %b 0", i, hreadyout[1], hresp[1], exp_rdy);
            end
            if (i == 0 || i == 2 || i == 5) begin
                checks++;
                if (hrdata[1] !== ((i == 0) ? 32'h0 : ref_mem[1][(i == 2) ? 0 : 1])) begin
                    errors++; $display("FAIL b2b_rdata[%0d]: rdata=%h", i, hrdata[1]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic r0, r1, eo;
        int w;
        logic [31:0] addrs [3];
        logic [2:0]  sizes [3];
        addrs = '{32'h400, 32'h1, 32'h8};
        sizes = '{3'd2, 3'd1, 3'd3};
        for (int k = 0; k < 3; k++) begin
            xfer(0, (k != 0), addrs[k], sizes[k], 32'hFFFF_FFFF, 1'b0, 4'd1, rd, r0, r1, eo, w);
            checks++;
            if (w !== 1 || r0 !== 1'b1 || r1 !== 1'b1 || rd !== 32'h0) begin
                errors++; $display("FAIL error_resp[%0d]: waits=%0d resp=%b/%b rdata=%h exp 1 1/1 0", k, w, r0, r1, rd);
            end
            xfer(0, 1'b0, addrs[k] & 32'h3FC, 3'd2, 32'h0, 1'b0, 4'd1, rd, r0, r1, eo, w);
            checks++;
            if (rd !== ref_mem[0][(addrs[k] & 32'h3FC) / 4]) begin
                errors++; $display("FAIL error_nowrite[%0d]: rdata=%h exp %h", k, rd, ref_mem[0][(addrs[k] & 32'h3FC) / 4]);
            end
        end
    endtask

    task automatic test_exclusive();
        logic [31:0] rd;
        logic r0, r1, eo;
        int w;
`ifdef AHBL_SLV_EXCL_EN
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, 1'b1, 4'd3, rd, r0, r1, eo, w);
        checks++;
        if (eo !== 1'b1 || rd !== ref_mem[0][8]) begin
            errors++; $display("FAIL excl_read1: exok=%b rdata=%h exp 1 %h", eo, rd, ref_mem[0][8]);
        end
        xfer(0, 1'b1, 32'h20, 3'd2, 32'h55, 1'b1, 4'd3, rd, r0, r1, eo, w);
        ref_mem[0][8] = 32'h55;
        checks++;
        if (eo !== 1'b1 || r1 !== 1'b0) begin
            errors++; $display("FAIL excl_write1: exok=%b resp=%b exp 1 0", eo, r1);
        end
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 4'd3, rd, r0, r1, eo, w);
        checks++;
        if (rd !== 32'h55 || eo !== 1'b0) begin
            errors++; $display("FAIL excl_data1: rdata=%h exok=%b exp 55 0", rd, eo);
        end
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, 1'b1, 4'd3, rd, r0, r1, eo, w);
        xfer(0, 1'b1, 32'h20, 3'd2, 32'h77, 1'b0, 4'd5, rd, r0, r1, eo, w);
        ref_mem[0][8] = 32'h77;
        xfer(0, 1'b1, 32'h20, 3'd2, 32'h99, 1'b1, 4'd3, rd, r0, r1, eo, w);
        checks++;
        if (eo !== 1'b0 || r1 !== 1'b0) begin
            errors++; $display("FAIL excl_write2: exok=%b resp=%b exp 0 0", eo, r1);
        end
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 4'd3, rd, r0, r1, eo, w);
        checks++;
        if (rd !== 32'h77) begin
            errors++; $display("FAIL excl_data2: rdata=%h exp 77", rd);
        end
`else
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, 1'b1, 4'd3, rd, r0, r1, eo, w);
        checks++;
        if (eo !== 1'b0 || rd !== ref_mem[0][8]) begin
            errors++; $display("FAIL excl_off_read: exok=%b rdata=%h exp 0 %h", eo, rd, ref_mem[0][8]);
        end
        xfer(0, 1'b1, 32'h20, 3'd2, 32'h55, 1'b1, 4'd3, rd, r0, r1, eo, w);
        ref_mem[0][8] = 32'h55;
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 4'd3, rd, r0, r1, eo, w);
        checks++;
        if (eo !== 1'b0 || rd !== 32'h55) begin
            errors++; $display("FAIL excl_off_write: exok=%b rdata=%h exp 0 55", eo, rd);
        end
`endif
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] rd;
        logic r0, r1, eo;
        int w;
        xfer(2, 1'b1, 32'h40, 3'd2, 32'h1111_2222, 1'b0, 4'd1, rd, r0, r1, eo, w);
        ref_mem[2][16] = 32'h1111_2222;
        hsel[2] = 1'b1; htrans[2] = 2'b10; haddr[2] = 32'h40; hsize[2] = 3'd2; hwrite[2] = 1'b1;
        @(posedge clk); #1;
        hsel[2] = 1'b0; htrans[2] = 2'b00; hwdata[2] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        checks++;
        if (hreadyout[2] !== 1'b0) begin
            errors++; $display("FAIL midreset_wait: rdy=%b exp 0", hreadyout[2]);
        end
        hrst[2] = 1'b1;
        #1;
        checks++;
        if (hreadyout[2] !== 1'b1 || hresp[2] !== 1'b0 || hrdata[2] !== 32'h0 || hexokay[2] !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: rdy=%b resp=%b rdata=%h exok=%b exp 1 0 0 0",
                               hreadyout[2], hresp[2], hrdata[2], hexokay[2]);
        end
        @(posedge clk); #1;
        hrst[2] = 1'b0;
        xfer(2, 1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 4'd1, rd, r0, r1, eo, w);
        checks++;
        if (rd !== 32'h1111_2222 || w !== 3 || r1 !== 1'b0) begin
            errors++; $display("FAIL midreset_after: rdata=%h waits=%0d resp=%b exp 11112222 3 0", rd, w, r1);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd;
        logic r0, r1, eo;
        int w, size;
        bit wr, bad;
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                addr = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 63))
                                                   : 32'($urandom_range(0, 71));
                size = $urandom_range(0, 3);
                wr   = 1'($urandom_range(0, 1));
                wd   = $urandom;
                bad  = is_illegal(addr, size);
                xfer(d, wr, addr, 3'(size), wd, 1'b0, 4'($urandom_range(0, 15)), rd, r0, r1, eo, w);
                checks++;
                if (bad && (w !== 1 || r0 !== 1'b1 || r1 !== 1'b1 || eo !== 1'b0)) begin
                    errors++; $display("FAIL rand_err dut%0d a=%h s=%0d: waits=%0d resp=%b/%b exok=%b exp 1 1/1 0",
                                       d, addr, size, w, r0, r1, eo);
                end else if (!bad && (w !== ws_of(d) || r0 !== 1'b0 || r1 !== 1'b0 || eo !== 1'b0)) begin
                    errors++; $display("FAIL rand_ok dut%0d a=%h s=%0d: waits=%0d resp=%b/%b exok=%b exp %0d 0/0 0",
                                       d, addr, size, w, r0, r1, eo, ws_of(d));
                end
                if (!bad && !wr) begin
                    checks++;
                    if (rd !== ref_mem[d][addr / 4]) begin
                        errors++; $display("FAIL rand_rdata dut%0d a=%h: rdata=%h exp %h", d, addr, rd, ref_mem[d][addr / 4]);
                    end
                end
                if (!bad && wr) ref_mem[d][addr / 4] = merge(ref_mem[d][addr / 4], wd, addr, size);
            end
        end
    endtask

    initial begin
        hburst = 3'd0; hprot = 7'd0; hmastlock = 1'b0; hnonsec = 1'b0;
        for (int d = 0; d < 3; d++) begin
            hrst[d] = 1'b1; hsel[d] = 1'b0; htrans[d] = 2'b00; hsize[d] = 3'd2; hwrite[d] = 1'b0;
            haddr[d] = 32'h0; hwdata[d] = 32'h0; hexcl[d] = 1'b0; hmaster[d] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        for (int d = 0; d < 3; d++) hrst[d] = 1'b0;
        @(posedge clk); #1;
        test_reset();
        init_mem();
        test_basic();
        test_lanes();
        test_back_to_back();
        test_errors();
        test_exclusive();
        test_reset_midwrite();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahblite_sram_slave.md
Name: ahblite_sram_slave

Overview:
- AHB-Lite responder (slave end) with flop-based word memory, sitting on one slave port of the AHB-Lite interconnect.
- Accepts address phases, inserts programmable wait states and applies HSIZE byte lanes.
- Signals a two-cycle ERROR for illegal transfers.
- Optionally tracks exclusive accesses and drives HEXOKAY.

Parameters:
- HADDR_WIDTH, 32, address width.
- HDATA_WIDTH, 32, data width; must be 32 or 64.
- MEM_DEPTH, 256, number of HDATA_WIDTH words.
- BASE_ADDR, 0, byte address of word 0.
- WAIT_STATES, 0, HREADYOUT-low cycles per OKAY data phase (0..15).

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  reset. One clock; reset is asynchronous and active-high.
- HSEL  in  1  slave select from interconnect decode.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HBURST  in  3  burst type; accepted, not used for addressing.
- HSIZE  in  3  transfer size (log2 bytes).
- HWRITE  in  1  1 = write.
- HADDR  in  HADDR_WIDTH  byte address.
- HWDATA  in  HDATA_WIDTH  write data (data phase).
- HMASTLOCK  in  1  ignored.
- HPROT  in  7  ignored.
- HNONSEC  in  1  ignored.
- HEXCL  in  1  exclusive transfer.
- HMASTER  in  4  master ID.
- HREADY  in  1  bus-level ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  HDATA_WIDTH  read data.
- HEXOKAY  out  1  exclusive okay.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, HEXOKAY=0, FSM=IDLE, exclusive monitor invalid. Memory array is not reset.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register addr, size, write, excl and master.
- IDLE/BUSY or unselected transfers get a zero-wait OKAY response.
- BL = log2(HDATA_WIDTH/8). off = HADDR - BASE_ADDR, computed at HADDR_WIDTH, wrap ignored.
- Transfer is illegal if any of:
  - off[HADDR_WIDTH-1:BL] >= MEM_DEPTH
  - HSIZE > BL
  - off & ((1<<HSIZE)-1) != 0 (misaligned)
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE, accept legal: WAIT_STATES=0 -> LAST; else WAIT with cnt=WAIT_STATES-1.
  - IDLE, accept illegal -> ERR1.
  - WAIT: HREADYOUT=0; cnt==0 -> LAST, else cnt--.
  - LAST: HREADYOUT=1, HRESP=0. A new accept in the same cycle follows the IDLE rules (back-to-back pipelining); otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept allowed as in LAST.
  - The address phase is only sampled while HREADY=1, so WAIT and ERR1 never accept.
- Read: HRDATA = mem[word_q] combinationally in LAST; 0 in all other states. The full word is driven; the master selects lanes.
- Write:
  - Byte strobes = ((1<<(1<<size_q))-1) << off_q[BL-1:0].
  - Strobed bytes of HWDATA are written at the rising edge ending LAST. No write occurs on ERROR.
  - A read to the same word in the very next transfer returns the new data, since the array is flops and there is no hazard logic.
- Exactly one response per accepted transfer. ERROR transfers never modify memory or the monitor.
- HRESET asserted mid-transfer: FSM -> IDLE and outputs return to reset values immediately (asynchronous). The partial transfer is dropped; no memory write occurs.

Optional Feature:
- Macro: AHBL_SLV_EXCL_EN.
- With the macro: single monitor {valid, master, word}.
  - Exclusive read, OKAY: set monitor to {1, master_q, word_q}; HEXOKAY=1 in LAST.
  - Exclusive write: if the monitor is valid and matches master and word, perform the write, HEXOKAY=1 in LAST, clear the monitor. Otherwise suppress the write, HEXOKAY=0, HRESP=OKAY.
  - Any committed non-exclusive write to the monitored word clears the monitor.
  - HEXOKAY=0 outside LAST.
- Without the macro: HEXCL ignored, HEXOKAY tied 0, exclusive writes behave as normal writes.

Decomposition:
- Shared package ahblite_pkg:
  - typedef htrans_e {IDLE, BUSY, NONSEQ, SEQ}.
  - typedef hsize_e.
  - HRESP_OKAY/HRESP_ERROR constants.
  - Function size_to_strb().
- Sub-module ahblite_excl_monitor, holding the monitor register and match logic; instantiated only under AHBL_SLV_EXCL_EN.

Test Plan:
1. WAIT_STATES=0: write word 0xA5A5_1234 to 0x10, then read 0x10.
   - Each data phase is one cycle with HREADYOUT=1.
   - Read returns HRDATA=0xA5A5_1234, HRESP=0.
2. Byte write 0xEE via HSIZE=0 to 0x13 over an existing 0x0000_0000 word -> readback 0xEE00_0000. Halfword write 0xBEEF to 0x12 -> readback 0xBEEF_0000.
3. WAIT_STATES=2: back-to-back NONSEQ reads to 0x0 and 0x4.
   - Each read gives 2 cycles HREADYOUT=0, then 1 cycle high.
   - The second address phase is accepted only on the ready cycle.
4. Error cases, each giving HREADYOUT 0 then 1 with HRESP=1 both cycles and memory unchanged:
   - Read at BASE_ADDR + 4*MEM_DEPTH.
   - HSIZE=1 write at 0x1.
   - HSIZE=3 write when HDATA_WIDTH=32.
5. With AHBL_SLV_EXCL_EN:
   - Master 3: exclusive read of 0x20 (HEXOKAY=1), then exclusive write 0x55 -> HEXOKAY=1, data written.
   - Repeat the sequence, but master 5 does a plain write to 0x20 in between -> master 3's exclusive write gives HEXOKAY=0 and memory holds master 5's value.
6. Assert HRESET during WAIT of a write with WAIT_STATES=3 -> outputs at reset values immediately, word unchanged. First transfer after release completes normally.
